// File: rtl/multi_cycle_control.sv
// Multi-cycle sequencer for the shared-memory, shared-ALU RV64 subset datapath.
// States: FETCH, DECODE, EXEC_R/EXEC_I/ADDR/BRANCH, MEM_RD/MEM_WR, ALU_WB/MEM_WB, ILLEGAL.
module multi_cycle_control (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] instr_op_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  output logic       PCWrite_o,
  output logic       IRWrite_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       MemtoReg_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] ALU_op_o,
  output logic       PCSource_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpLd  = 7'b0000011;
  localparam logic [6:0] OpSd  = 7'b0100011;
  localparam logic [6:0] OpBeq = 7'b1100011;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBFour = 2'b01;
  localparam logic [1:0] SrcBImm  = 2'b10;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EXEC_R  = 4'd2,
    EXEC_I  = 4'd3,
    ALU_WB  = 4'd4,
    ADDR    = 4'd5,
    MEM_RD  = 4'd6,
    MEM_WB  = 4'd7,
    MEM_WR  = 4'd8,
    BRANCH  = 4'd9,
    ILLEGAL = 4'd10
  } state_t;

  state_t stateQ;
  state_t stateNext;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stateQ <= FETCH;
    end else begin
      stateQ <= stateNext;
    end
  end

  always_comb begin
    stateNext = FETCH;
    case (stateQ)
      FETCH:   stateNext = mem_ready_i ? DECODE : FETCH;
      DECODE: begin
        case (instr_op_i)
          OpR:         stateNext = EXEC_R;
          OpI:         stateNext = EXEC_I;
          OpLd, OpSd:  stateNext = ADDR;
          OpBeq:       stateNext = BRANCH;
          default:     stateNext = ILLEGAL;
        endcase
      end
      EXEC_R:  stateNext = ALU_WB;
      EXEC_I:  stateNext = ALU_WB;
      ALU_WB:  stateNext = FETCH;
      // IR is frozen outside FETCH, so the opcode seen here is the decoded one
      ADDR: begin
        if (instr_op_i == OpLd) begin
          stateNext = MEM_RD;
        end else if (instr_op_i == OpSd) begin
          stateNext = MEM_WR;
        end else begin
          stateNext = ILLEGAL;
        end
      end
      MEM_RD:  stateNext = mem_ready_i ? MEM_WB : MEM_RD;
      MEM_WB:  stateNext = FETCH;
      MEM_WR:  stateNext = mem_ready_i ? FETCH : MEM_WR;
      BRANCH:  stateNext = FETCH;
      ILLEGAL: stateNext = FETCH;
      default: stateNext = FETCH;
    endcase
  end

  // Outputs are forced low while reset is held so no strobe survives an abort.
  always_comb begin
    PCWrite_o    = 1'b0;
    IRWrite_o    = 1'b0;
    IorD_o       = 1'b0;
    MemRead_o    = 1'b0;
    MemWrite_o   = 1'b0;
    MemtoReg_o   = 1'b0;
    RegWrite_o   = 1'b0;
    ALUSrcA_o    = 1'b0;
    ALUSrcB_o    = SrcBRs2;
    ALU_op_o     = AluAdd;
    PCSource_o   = 1'b0;
    instr_done_o = 1'b0;
    illegal_o    = 1'b0;
    state_o      = 4'd0;
    if (!rst_i) begin
      state_o = stateQ;
      case (stateQ)
        FETCH: begin
          MemRead_o = 1'b1;
          ALUSrcB_o = SrcBFour;
          IRWrite_o = mem_ready_i;
          PCWrite_o = mem_ready_i;
        end
        DECODE: begin
          ALUSrcB_o = SrcBImm;
        end
        EXEC_R: begin
          ALUSrcA_o = 1'b1;
          ALUSrcB_o = SrcBRs2;
          ALU_op_o  = AluFunct;
        end
        EXEC_I, ADDR: begin
          ALUSrcA_o = 1'b1;
          ALUSrcB_o = SrcBImm;
        end
        ALU_WB: begin
          RegWrite_o   = 1'b1;
          instr_done_o = 1'b1;
        end
        MEM_RD: begin
          IorD_o    = 1'b1;
          MemRead_o = 1'b1;
        end
        MEM_WB: begin
          RegWrite_o   = 1'b1;
          MemtoReg_o   = 1'b1;
          instr_done_o = 1'b1;
        end
        MEM_WR: begin
          IorD_o       = 1'b1;
          MemWrite_o   = 1'b1;
          instr_done_o = mem_ready_i;
        end
        BRANCH: begin
          ALUSrcA_o    = 1'b1;
          ALUSrcB_o    = SrcBRs2;
          ALU_op_o     = AluSub;
          PCSource_o   = 1'b1;
          PCWrite_o    = zero_i;
          instr_done_o = 1'b1;
        end
        ILLEGAL: begin
          illegal_o = 1'b1;
        end
        default: begin
          illegal_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: a per-instruction expected-cycle model
// plus literal state sequences and latencies.
module tb_multi_cycle_control;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [6:0] instr_op_i = 7'd0;
  logic       mem_ready_i = 1'b1;
  logic       zero_i = 1'b0;
  logic       PCWrite_o, IRWrite_o, IorD_o, MemRead_o, MemWrite_o, MemtoReg_o;
  logic       RegWrite_o, ALUSrcA_o, PCSource_o, instr_done_o, illegal_o;
  logic [1:0] ALUSrcB_o, ALU_op_o;
  logic [3:0] state_o;

  multi_cycle_control dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
    .zero_i(zero_i), .PCWrite_o(PCWrite_o), .IRWrite_o(IRWrite_o), .IorD_o(IorD_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .MemtoReg_o(MemtoReg_o),
    .RegWrite_o(RegWrite_o), .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o),
    .ALU_op_o(ALU_op_o), .PCSource_o(PCSource_o), .instr_done_o(instr_done_o),
    .illegal_o(illegal_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_SD = 7'b0100011, OP_BEQ = 7'b1100011, OP_BAD = 7'b1111111;

  typedef struct packed {
    logic       pcWrite, irWrite, iorD, memRead, memWrite, memtoReg, regWrite, aluSrcA;
    logic [1:0] aluSrcB, aluOp;
    logic       pcSource, instrDone, illegal;
    logic [3:0] state;
  } outs_t;

  typedef struct packed {
    logic       rst, rdy, zero;
    logic [6:0] op;
    outs_t      o;
  } rec_t;

  int    checks = 0;
  int    failures = 0;
  rec_t  expQ[$];
  int    seqQ[$];
  int    refQ[$];
  outs_t expO;
  bit    expValid = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // What the datapath must see in each phase of an instruction.
  function automatic outs_t outsFor(input int s, input bit rdy, input bit z);
    outs_t o = '0;
    o.state = 4'(s);
    case (s)
      0:  begin o.memRead = 1; o.aluSrcB = 2'b01; o.irWrite = rdy; o.pcWrite = rdy; end
      1:  o.aluSrcB = 2'b10;
      2:  begin o.aluSrcA = 1; o.aluSrcB = 2'b00; o.aluOp = 2'b10; end
      3, 5: begin o.aluSrcA = 1; o.aluSrcB = 2'b10; end
      4:  begin o.regWrite = 1; o.instrDone = 1; end
      6:  begin o.iorD = 1; o.memRead = 1; end
      7:  begin o.regWrite = 1; o.memtoReg = 1; o.instrDone = 1; end
      8:  begin o.iorD = 1; o.memWrite = 1; o.instrDone = rdy; end
      9:  begin o.aluSrcA = 1; o.aluOp = 2'b01; o.pcSource = 1; o.pcWrite = z; o.instrDone = 1; end
      10: o.illegal = 1;
      default: o = '0;
    endcase
    return o;
  endfunction

  // Ready/zero are driven opposite to their meaningful value wherever they should be ignored.
  function automatic void push(input logic [6:0] op, input int s, input bit rdy, input bit z);
    rec_t r;
    r.rst = 0; r.rdy = rdy; r.zero = z; r.op = op;
    r.o = outsFor(s, rdy, z);
    expQ.push_back(r);
  endfunction

  function automatic void build(input logic [6:0] op, input int fw, input int mw, input bit z);
    expQ.delete();
    for (int i = 0; i < fw; i++) push(op, 0, 0, 1);
    push(op, 0, 1, 1);
    push(op, 1, 0, 1);
    case (op)
      OP_R:   begin push(op, 2, 0, 1); push(op, 4, 0, 1); end
      OP_I:   begin push(op, 3, 0, 1); push(op, 4, 0, 1); end
      OP_LD:  begin
        push(op, 5, 0, 1);
        for (int i = 0; i < mw; i++) push(op, 6, 0, 1);
        push(op, 6, 1, 1);
        push(op, 7, 0, 1);
      end
      OP_SD:  begin
        push(op, 5, 0, 1);
        for (int i = 0; i < mw; i++) push(op, 8, 0, 1);
        push(op, 8, 1, 1);
      end
      OP_BEQ: push(op, 9, 0, z);
      default: push(op, 10, 0, 1);
    endcase
  endfunction

  task automatic play(input int n);
    seqQ.delete();
    for (int i = 0; i < n && i < expQ.size(); i++) begin
      @(negedge clk_i);
      rst_i = expQ[i].rst; mem_ready_i = expQ[i].rdy; zero_i = expQ[i].zero;
      instr_op_i = expQ[i].op; expO = expQ[i].o; expValid = 1;
    end
    #3;
    expValid = 0;
  endtask

  task automatic checkSeq(input string name);
    check({name, "_len"}, seqQ.size(), refQ.size());
    for (int i = 0; i < refQ.size() && i < seqQ.size(); i++)
      check($sformatf("%s_st%0d", name, i), seqQ[i], refQ[i]);
  endtask

  always @(negedge clk_i) begin
    #2;
    if (expValid) begin
      outs_t act;
      act = {PCWrite_o, IRWrite_o, IorD_o, MemRead_o, MemWrite_o, MemtoReg_o, RegWrite_o,
             ALUSrcA_o, ALUSrcB_o, ALU_op_o, PCSource_o, instr_done_o, illegal_o, state_o};
      check($sformatf("outs_in_state%0d", expO.state), act, expO);
      seqQ.push_back(int'(state_o));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rec_t r;
    // Reset held 3 cycles with ready high: everything must be quiet.
    expQ.delete();
    r = '0; r.rst = 1; r.rdy = 1;
    for (int i = 0; i < 3; i++) expQ.push_back(r);
    play(3);
    refQ = '{0, 0, 0}; checkSeq("reset");

    build(OP_R, 0, 0, 0);  check("r_model_len", expQ.size(), 4);  play(99);
    refQ = '{0, 1, 2, 4}; checkSeq("add");

    build(OP_LD, 0, 2, 0); check("ld_model_len", expQ.size(), 7); play(99);
    refQ = '{0, 1, 5, 6, 6, 6, 7}; checkSeq("ld_wait2");

    build(OP_BEQ, 0, 0, 1); play(99);
    refQ = '{0, 1, 9}; checkSeq("beq_taken");
    check("beq_taken_pcwrite_model", expQ[2].o.pcWrite, 1);

    build(OP_BEQ, 0, 0, 0); play(99);
    refQ = '{0, 1, 9}; checkSeq("beq_not_taken");
    check("beq_nt_pcwrite_model", expQ[2].o.pcWrite, 0);

    build(OP_SD, 1, 0, 0); play(99);
    refQ = '{0, 0, 1, 5, 8}; checkSeq("sd_fetchwait");

    build(OP_BAD, 0, 0, 0); play(99);
    refQ = '{0, 1, 10}; checkSeq("illegal");

    build(OP_I, 0, 0, 0); play(99);
    refQ = '{0, 1, 3, 4}; checkSeq("addi");

    build(OP_SD, 2, 2, 0); play(99);
    refQ = '{0, 0, 0, 1, 5, 8, 8, 8}; checkSeq("sd_waits");

    // Abort a store while it is waiting on memory.
    build(OP_SD, 0, 3, 0); play(4);
    @(negedge clk_i);
    mem_ready_i = 0;
    #1 check("abort_memwrite_before", MemWrite_o, 1);
    #2 rst_i = 1;
    #1;
    check("abort_memwrite_after", MemWrite_o, 0);
    check("abort_done_after", instr_done_o, 0);
    check("abort_state_after", state_o, 0);
    check("abort_memread_after", MemRead_o, 0);
    @(negedge clk_i);
    #1 check("abort_held_iorD", IorD_o, 0);

    build(OP_R, 0, 0, 0); play(99);
    refQ = '{0, 1, 2, 4}; checkSeq("add_after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
